// File: rtl/dmem_lsu_pkg.sv
// Shared types and constants for the data-memory load/store unit.
package dmem_lsu_pkg;

    // Access size encoding, matching the req_size field of the core request.
    typedef enum logic [1:0] {
        SZ_B   = 2'b00,
        SZ_H   = 2'b01,
        SZ_W   = 2'b10,
        SZ_ILL = 2'b11
    } size_e;

    // Control states of the LSU sequencer.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        RMW_RD = 3'd2,
        WRITE  = 3'd3,
        RESP   = 3'd4
    } state_e;

    localparam int NLANES = 4;
    localparam int LANE_W = 8;
    localparam int WORD_W = NLANES * LANE_W;

    // Returns 1 when the size is illegal or the byte offset is not aligned to the size.
    function automatic logic access_error(input size_e size, input logic [1:0] offset);
        logic err;
        err = 1'b0;
        case (size)
            SZ_B:    err = 1'b0;
            SZ_H:    err = offset[0];
            SZ_W:    err = |offset;
            default: err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/dmem_lsu_lane.sv
// Byte-lane datapath: load extraction/extension and sub-word store merge.
module dmem_lsu_lane
    import dmem_lsu_pkg::*;
(
    input  logic [WORD_W-1:0] word,
    input  logic [1:0]        offset,
    input  size_e             size,
    input  logic              is_unsigned,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] load_data,
    output logic [WORD_W-1:0] merge_data
);

    // Aligned accesses let a plain byte shift bring the addressed lane(s) down to bit 0.
    logic [WORD_W-1:0] shifted;
    assign shifted = word >> {offset, 3'b000};

    // Extract the addressed byte/half and sign- or zero-extend it.
    always_comb begin
        load_data = word;
        case (size)
            SZ_B:    load_data = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
            SZ_H:    load_data = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
            default: load_data = word;
        endcase
    end

    // Each lane picks either the old memory byte or the matching store byte.
    for (genvar gi = 0; gi < NLANES; gi++) begin : g_lane
        localparam logic [1:0] LANE = 2'(gi);
        logic              lane_en;
        logic [LANE_W-1:0] lane_byte;

        // Decide whether this lane is written and which store byte lands in it.
        always_comb begin
            lane_en   = 1'b1;
            lane_byte = wdata[LANE_W*gi +: LANE_W];
            case (size)
                SZ_B: begin
                    lane_en   = (offset == LANE);
                    lane_byte = wdata[7:0];
                end
                SZ_H: begin
                    lane_en   = (offset[1] == LANE[1]);
                    lane_byte = LANE[0] ? wdata[15:8] : wdata[7:0];
                end
                default: begin
                    lane_en   = 1'b1;
                    lane_byte = wdata[LANE_W*gi +: LANE_W];
                end
            endcase
        end

        assign merge_data[LANE_W*gi +: LANE_W] = lane_en ? lane_byte : word[LANE_W*gi +: LANE_W];
    end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit: sequences byte-addressed core requests into word accesses
// on a single-port data memory, with read-modify-write for sub-word stores.
module dmem_lsu
    import dmem_lsu_pkg::*;
#(
    parameter int AWIDTH = 8,
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [AWIDTH+1:0] req_addr,
    input  logic [DWIDTH-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DWIDTH-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_wdata,
    output logic              mem_wen,
    input  logic [DWIDTH-1:0] mem_rdata
);

    state_e             state_reg, state_next;
    logic               we_reg;
    size_e              size_reg;
    logic               uns_reg;
    logic [AWIDTH+1:0]  addr_reg;
    logic [DWIDTH-1:0]  wdata_reg;
    logic               err_reg;
    logic [DWIDTH-1:0]  rdata_reg;
    logic [DWIDTH-1:0]  merge_reg;

    size_e              req_size_e;
    logic               accept;
    logic               req_err;
    logic [DWIDTH-1:0]  load_data;
    logic [DWIDTH-1:0]  merge_data;

    assign req_size_e = size_e'(req_size);
    assign accept     = (state_reg == IDLE) && req_valid;
    assign req_err    = access_error(req_size_e, req_addr[1:0]);

    // The lane unit sees the live memory word; LOAD and RMW_RD each sample the result they need.
    dmem_lsu_lane u_lane (
        .word        (mem_rdata),
        .offset      (addr_reg[1:0]),
        .size        (size_reg),
        .is_unsigned (uns_reg),
        .wdata       (wdata_reg),
        .load_data   (load_data),
        .merge_data  (merge_data)
    );

    // State register; reset abandons any in-flight access before its write edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state selection: errors skip memory, word stores skip the read phase.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (req_err)                 state_next = RESP;
                    else if (!req_we)            state_next = LOAD;
                    else if (req_size_e == SZ_W) state_next = WRITE;
                    else                         state_next = RMW_RD;
                end
            end
            LOAD:    state_next = RESP;
            RMW_RD:  state_next = WRITE;
            WRITE:   state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request capture at accept, plus load result and merge word captured in their states.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_reg    <= 1'b0;
            size_reg  <= SZ_B;
            uns_reg   <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            err_reg   <= 1'b0;
            rdata_reg <= '0;
            merge_reg <= '0;
        end else begin
            if (accept) begin
                we_reg    <= req_we;
                size_reg  <= req_size_e;
                uns_reg   <= req_unsigned;
                addr_reg  <= req_addr;
                wdata_reg <= req_wdata;
                err_reg   <= req_err;
                rdata_reg <= '0;
            end
            if (state_reg == LOAD) begin
                rdata_reg <= load_data;
            end
            if (state_reg == RMW_RD) begin
                merge_reg <= merge_data;
            end
        end
    end

    // Outputs decode from the state so reset drives them to idle values immediately.
    always_comb begin
        req_ready = (state_reg == IDLE);
        rsp_valid = (state_reg == RESP);
        rsp_rdata = '0;
        rsp_err   = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wen   = 1'b0;
        if (state_reg == RESP) begin
            rsp_rdata = we_reg ? '0 : rdata_reg;
            rsp_err   = err_reg;
        end
        if (state_reg == LOAD || state_reg == RMW_RD || state_reg == WRITE) begin
            mem_addr = addr_reg[AWIDTH+1:2];
        end
        if (state_reg == WRITE) begin
            mem_wen   = 1'b1;
            mem_wdata = (size_reg == SZ_W) ? wdata_reg : merge_reg;
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu with a behavioural single-port data memory.
module tb_dmem_lsu;

    localparam int AWIDTH = 8;
    localparam int DWIDTH = 32;
    localparam logic [1:0] B   = 2'b00;
    localparam logic [1:0] H   = 2'b01;
    localparam logic [1:0] W   = 2'b10;
    localparam logic [1:0] ILL = 2'b11;

    logic              clk;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [AWIDTH+1:0] req_addr;
    logic [DWIDTH-1:0] req_wdata;
    logic              rsp_valid;
    logic [DWIDTH-1:0] rsp_rdata;
    logic              rsp_err;
    logic [AWIDTH-1:0] mem_addr;
    logic [DWIDTH-1:0] mem_wdata;
    logic              mem_wen;
    logic [DWIDTH-1:0] mem_rdata;

    logic [DWIDTH-1:0] mem [0:(1<<AWIDTH)-1];

    int checks   = 0;
    int failures = 0;

    dmem_lsu #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_wen      (mem_wen),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_wen) mem[mem_addr] <= mem_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'(req_ready), 32'd1);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
        chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_mem_wen"}, 32'(mem_wen), 32'd0);
    endtask

    // Issue one request, then watch until rsp_valid (bounded), recording latency and writes.
    task automatic run_req(input logic we, input logic [1:0] sz, input logic uns,
                           input logic [AWIDTH+1:0] addr, input logic [31:0] wd,
                           output int lat, output logic [31:0] rd, output logic er,
                           output int wens, output logic [7:0] wa, output logic [31:0] wdv,
                           output int wcyc);
        lat = 0; rd = 32'hFFFF_FFFF; er = 1'bx; wens = 0; wa = 8'h00; wdv = 32'h0; wcyc = 0;
        @(negedge clk);
        req_we = we; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wd;
        req_valid = 1'b1;
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        while (lat < 8) begin
            @(negedge clk);
            lat++;
            if (lat == 1) req_valid = 1'b0;
            if (mem_wen) begin
                wens++; wa = mem_addr; wdv = mem_wdata; wcyc = lat;
            end
            if (rsp_valid) begin
                rd = rsp_rdata; er = rsp_err;
                break;
            end
        end
        $display("txn we=%0d size=%0d uns=%0d addr=0x%03h wdata=0x%08h -> lat=%0d rdata=0x%08h err=%0d wens=%0d",
                 we, sz, uns, addr, wd, lat, rd, er, wens);
    endtask

    initial begin
        int          lat, wens, wcyc;
        logic [31:0] rd, wdv;
        logic        er;
        logic [7:0]  wa;

        for (int i = 0; i < (1 << AWIDTH); i++) mem[i] = 32'h0;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = B;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;

        // Reset values
        #2;
        chk_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // SW 0x08 DEADBEEF
        run_req(1'b1, W, 1'b0, 10'h008, 32'hDEADBEEF, lat, rd, er, wens, wa, wdv, wcyc);
        chk("sw_lat", 32'(lat), 32'd2);
        chk("sw_err", 32'(er), 32'd0);
        chk("sw_rdata", rd, 32'd0);
        chk("sw_wens", 32'(wens), 32'd1);
        chk("sw_wcyc", 32'(wcyc), 32'd1);
        chk("sw_maddr", 32'(wa), 32'd2);
        chk("sw_mwdata", wdv, 32'hDEADBEEF);

        // LW 0x08
        run_req(1'b0, W, 1'b0, 10'h008, 32'h0, lat, rd, er, wens, wa, wdv, wcyc);
        chk("lw_lat", 32'(lat), 32'd2);
        chk("lw_rdata", rd, 32'hDEADBEEF);
        chk("lw_err", 32'(er), 32'd0);
        chk("lw_wens", 32'(wens), 32'd0);

        // Sub-word loads
        run_req(1'b0, B, 1'b0, 10'h00B, 32'h0, lat, rd, er, wens, wa, wdv, wcyc);
        chk("lb_rdata", rd, 32'hFFFFFFDE);
        chk("lb_lat", 32'(lat), 32'd2);
        run_req(1'b0, B, 1'b1, 10'h00B, 32'h0, lat, rd, er, wens, wa, wdv, wcyc);
        chk("lbu_rdata", rd, 32'h000000DE);
        run_req(1'b0, H, 1'b0, 10'h00A, 32'h0, lat, rd, er, wens, wa, wdv, wcyc);
        chk("lh_rdata", rd, 32'hFFFFDEAD);
        run_req(1'b0, H, 1'b1, 10'h008, 32'h0, lat, rd, er, wens, wa, wdv, wcyc);
        chk("lhu_rdata", rd, 32'h0000BEEF);
        run_req(1'b0, B, 1'b0, 10'h008, 32'h0, lat, rd, er, wens, wa, wdv, wcyc);
        chk("lb0_rdata", rd, 32'hFFFFFFEF);
        run_req(1'b0, B, 1'b0, 10'h009, 32'h0, lat, rd, er, wens, wa, wdv, wcyc);
        chk("lb1_rdata", rd, 32'hFFFFFFBE);

        // SB 0x09 via read-modify-write
        run_req(1'b1, B, 1'b0, 10'h009, 32'h12345677, lat, rd, er, wens, wa, wdv, wcyc);
        chk("sb_lat", 32'(lat), 32'd3);
        chk("sb_wcyc", 32'(wcyc), 32'd2);
        chk("sb_wens", 32'(wens), 32'd1);
        chk("sb_maddr", 32'(wa), 32'd2);
        chk("sb_mwdata", wdv, 32'hDEAD77EF);
        chk("sb_err", 32'(er), 32'd0);
        run_req(1'b0, W, 1'b0, 10'h008, 32'h0, lat, rd, er, wens, wa, wdv, wcyc);
        chk("lw_after_sb", rd, 32'hDEAD77EF);

        // SH 0x12 into zero word 4 (upper half)
        run_req(1'b1, H, 1'b0, 10'h012, 32'hAAAA8001, lat, rd, er, wens, wa, wdv, wcyc);
        chk("sh_lat", 32'(lat), 32'd3);
        chk("sh_mwdata", wdv, 32'h80010000);
        chk("sh_maddr", 32'(wa), 32'd4);
        run_req(1'b0, H, 1'b0, 10'h012, 32'h0, lat, rd, er, wens, wa, wdv, wcyc);
        chk("lh_after_sh", rd, 32'hFFFF8001);

        // Misaligned and illegal
        run_req(1'b0, W, 1'b0, 10'h006, 32'h0, lat, rd, er, wens, wa, wdv, wcyc);
        chk("lw_mis_lat", 32'(lat), 32'd1);
        chk("lw_mis_err", 32'(er), 32'd1);
        chk("lw_mis_rdata", rd, 32'd0);
        chk("lw_mis_wens", 32'(wens), 32'd0);
        run_req(1'b1, H, 1'b0, 10'h005, 32'hFFFFFFFF, lat, rd, er, wens, wa, wdv, wcyc);
        chk("sh_mis_lat", 32'(lat), 32'd1);
        chk("sh_mis_err", 32'(er), 32'd1);
        chk("sh_mis_rdata", rd, 32'd0);
        chk("sh_mis_wens", 32'(wens), 32'd0);
        run_req(1'b0, ILL, 1'b0, 10'h008, 32'h0, lat, rd, er, wens, wa, wdv, wcyc);
        chk("ill_lat", 32'(lat), 32'd1);
        chk("ill_err", 32'(er), 32'd1);
        run_req(1'b0, W, 1'b0, 10'h008, 32'h0, lat, rd, er, wens, wa, wdv, wcyc);
        chk("lw_after_err", rd, 32'hDEAD77EF);

        // Held request: SB 0x0C then LW 0x0C waiting with req_valid high
        wens = 0;
        @(negedge clk);
        req_we = 1'b1; req_size = B; req_unsigned = 1'b0; req_addr = 10'h00C;
        req_wdata = 32'h000000AB; req_valid = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            if (c == 1) begin
                req_we = 1'b0; req_size = W; req_addr = 10'h00C; req_wdata = 32'h0;
            end
            chk("held_ready_busy", 32'(req_ready), 32'd0);
            if (mem_wen) wens++;
        end
        chk("held_rsp1", 32'(rsp_valid), 32'd1);
        @(negedge clk);
        chk("held_ready_t4", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        if (mem_wen) wens++;
        chk("held_load_busy", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        if (mem_wen) wens++;
        chk("held_rsp2", 32'(rsp_valid), 32'd1);
        chk("held_rdata", rsp_rdata, 32'h000000AB);
        chk("held_wens", 32'(wens), 32'd1);
        $display("txn held SB 0x00C then LW 0x00C -> rdata=0x%08h wens=%0d", rsp_rdata, wens);

        // Reset during RMW_RD of SH 0x08
        @(negedge clk);
        req_we = 1'b1; req_size = H; req_unsigned = 1'b0; req_addr = 10'h008;
        req_wdata = 32'h00005555; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rst_rmw_maddr", 32'(mem_addr), 32'd2);
        chk("rst_rmw_ready", 32'(req_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        wens = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (mem_wen) wens++;
        end
        chk("midrst_wens", 32'(wens), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        $display("txn reset during SH 0x008 RMW_RD -> wens=%0d", wens);
        run_req(1'b0, W, 1'b0, 10'h008, 32'h0, lat, rd, er, wens, wa, wdv, wcyc);
        chk("lw_after_rst", rd, 32'hDEAD77EF);
        chk("lw_after_rst_lat", 32'(lat), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
